// File: rtl/cf_util_fifo_wr_arb.sv
// Round-robin packet write arbiter in front of a single cf_util_fifo write port.
// Grants are held for a whole packet; FIFO writes are registered and space-checked.
module cf_util_fifo_wr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_last,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              fifo_wr,
    output logic [DW-1:0]     fifo_w_data,
    input  logic [AW:0]       fifo_level,
    output logic              locked,
    output logic [IDW-1:0]    grant_id,
    output logic [15:0]       pkt_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam int LW    = AW + 2;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic             fifo_wr_q, fifo_wr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             locked_q, locked_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;

    logic             space;
    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [IDW-1:0]   sel;
    logic             sel_ok;
    logic [NREQ-1:0]  ready_c;
    int               idx;

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] i);
        next_ptr = (int'(i) >= NREQ - 1) ? '0 : i + 1'b1;
    endfunction

    // Pending registered write is not yet visible in fifo_level
    assign space = (LW'(fifo_level) + LW'(fifo_wr_q)) < LW'(DEPTH);

    // Downward scan so the lowest offset from rr_ptr wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        fifo_wr_d = 1'b0;
        wdata_d   = wdata_q;
        locked_d  = locked_q;
        pkt_cnt_d = pkt_cnt_q;
        ready_c   = '0;
        sel       = (state_q == LOCKED) ? grant_q : win_idx;
        sel_ok    = (state_q == LOCKED) ? req_valid[grant_q] : win_found;
        if (sel_ok && space) begin
            ready_c[sel] = 1'b1;
            fifo_wr_d    = 1'b1;
            wdata_d      = req_data[sel*DW +: DW];
            grant_d      = sel;
            if (req_last[sel]) begin
                state_d   = ARB;
                locked_d  = 1'b0;
                rr_ptr_d  = next_ptr(sel);
                pkt_cnt_d = pkt_cnt_q + 16'd1;
            end else begin
                state_d  = LOCKED;
                locked_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            fifo_wr_q <= 1'b0;
            wdata_q   <= '0;
            locked_q  <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            fifo_wr_q <= fifo_wr_d;
            wdata_q   <= wdata_d;
            locked_q  <= locked_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign req_ready   = ready_c & {NREQ{~rst}};
    assign fifo_wr     = fifo_wr_q;
    assign fifo_w_data = wdata_q;
    assign locked      = locked_q;
    assign grant_id    = grant_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule
